tlb_unit: RTL and testbench
===========================

// Module: tlb_unit
// PURPOSE
// - Fully associative MIPS32 joint TLB: the responder for the CP0 TLB interface (tlbwi/tlbr/tlbp) and the
//   translator for the fetch (port s0) and memory (port s1) stages. Holds TLBNUM entries of
//   {VPN2, ASID, G, PFN0/C0/D0/V0, PFN1/C1/D1/V1}.
// - Lookup, probe and read results are registered with 1-cycle latency. Writes commit at the clock edge.
// PARAMETERS
// - TLBNUM  16  number of entries
// - IDX_W    4  index width, = clog2(TLBNUM)
// PORTS
// - clk          in   1   clock
// - reset        in   1   reset, synchronous, active-high
// - sK_req       in   1   lookup request, K in {0,1}
// - sK_vpn2      in   19  VA[31:13]
// - sK_odd_page  in   1   VA[12]
// - sK_asid      in   8   current ASID
// - sK_rsp_vld   out  1   response valid, sK_req delayed by one cycle
// - sK_found     out  1   hit
// - sK_index     out  IDX_W  matching entry index
// - sK_pfn       out  20  PFN of the selected page; sK_c out 3, sK_d out 1, sK_v out 1
// - p_req        in   1   probe (tlbp), using p_vpn2 in 19 and p_asid in 8
// - p_done       out  1   probe result valid; p_found out 1; p_index out IDX_W
// - we           in   1   write (tlbwi/tlbwr) to w_index in IDX_W
// - w_vpn2 in 19, w_asid in 8, w_g in 1, w_pfn0 in 20, w_c0 in 3, w_d0/w_v0 in 1, w_pfn1 in 20, w_c1 in 3, w_d1/w_v1 in 1
// - r_req        in   1   read (tlbr) of r_index in IDX_W
// - r_done       out  1   read data valid
// - r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  same widths as w_*
// BEHAVIOUR
// - Storage: per entry, all fields plus a private e_vld bit. Reset clears every field and e_vld.
//   An entry with e_vld=0 never matches. A read of an entry that was never written returns all zeros.
// - Match for entry i: e_vld[i] && vpn2==e_vpn2[i] && (e_g[i] || asid==e_asid[i]).
//   The page is selected by odd_page: 0 selects PFN0/C0/D0/V0, 1 selects PFN1/C1/D1/V1.
// - Multiple hits: the lowest index wins. Entries are never checked for duplicates.
// - Lookup timing: a match is computed combinationally in cycle N and registered at edge N+1.
//   Results are then visible and held until the next sK_req.
// - Lookup miss: sK_found=0, sK_index=0, sK_pfn/c/d/v=0. The fetch and memory stages raise TLBL/TLBS.
//   Those stages also raise Mod when found && !d on a store, and TLB invalid when found && !v.
// - Probe: same match rule on p_vpn2/p_asid, with no page select. p_done, p_found and p_index register
//   on the next edge. CP0 sets Index.P = !p_found.
// - Read: r_done and r_* register r_index contents on the next edge. Outputs hold until the next r_req.
// - Write: entry w_index is updated and e_vld set at the edge where we=1.
// - Same-cycle events: a lookup, probe or read in the same cycle as a write to the same entry sees
//   the OLD contents. Ports s0, s1, probe, read and write are all independent and may fire every cycle.
// - Reset values: sK_rsp_vld=0, p_done=0, r_done=0, and every data output = 0.
//   Reset asserted mid-request drops the pending response (no *_vld/done the following cycle).
// - No internal state machine beyond the response-valid pipeline registers. Throughput is 1 op/cycle per port.
// TESTING
// - After reset, s0_req with vpn2=0, asid=0 -> next cycle s0_rsp_vld=1 and s0_found=0.
//   Also r_req index 3 -> all r_* = 0.
// - Write index 5: vpn2=19'h00400, asid=8'h12, g=0, pfn0=20'h1A, pfn1=20'h1B, v0=v1=1, d1=1.
//   Then s1 lookup vpn2=19'h00400, asid=8'h12, odd=1 -> found=1, index=5, pfn=20'h1B, d=1.
//   The same lookup with asid=8'h13 -> found=0.
// - Rewrite index 5 with g=1. Lookup asid=8'h77, odd=0 -> found=1, pfn=20'h1A.
//   Probe with the same vpn2 -> p_found=1, p_index=5.
// - Write index 2 and index 9 with an identical vpn2/asid. Lookup -> s0_index=2.
//   Then invalidate index 2 by rewriting it with a different vpn2. Lookup -> s0_index=9.
// - Same cycle: we to index 7 with a new vpn2, plus a lookup of the old vpn2 of index 7 -> hit on the old data.
//   The following lookup of the old vpn2 -> miss.
// - Assert reset with s0_req=1, p_req=1 and r_req=1 in the same cycle.
//   Next cycle: s0_rsp_vld=0, p_done=0 and r_done=0. All previously written entries miss.

Source files
------------

// File: rtl/tlb_unit.sv
`default_nettype none
// tlb_unit: fully associative MIPS32 joint TLB with two translation ports, probe, read and indexed write.
// Revision 1.0
module tlb_unit #(
   parameter int TLBNUM = 16,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s0_req,
   input  logic [18:0]      s0_vpn2,
   input  logic             s0_odd_page,
   input  logic [7:0]       s0_asid,
   output logic             s0_rsp_vld,
   output logic             s0_found,
   output logic [IDX_W-1:0] s0_index,
   output logic [19:0]      s0_pfn,
   output logic [2:0]       s0_c,
   output logic             s0_d,
   output logic             s0_v,
   input  logic             s1_req,
   input  logic [18:0]      s1_vpn2,
   input  logic             s1_odd_page,
   input  logic [7:0]       s1_asid,
   output logic             s1_rsp_vld,
   output logic             s1_found,
   output logic [IDX_W-1:0] s1_index,
   output logic [19:0]      s1_pfn,
   output logic [2:0]       s1_c,
   output logic             s1_d,
   output logic             s1_v,
   input  logic             p_req,
   input  logic [18:0]      p_vpn2,
   input  logic [7:0]       p_asid,
   output logic             p_done,
   output logic             p_found,
   output logic [IDX_W-1:0] p_index,
   input  logic             we,
   input  logic [IDX_W-1:0] w_index,
   input  logic [18:0]      w_vpn2,
   input  logic [7:0]       w_asid,
   input  logic             w_g,
   input  logic [19:0]      w_pfn0,
   input  logic [2:0]       w_c0,
   input  logic             w_d0,
   input  logic             w_v0,
   input  logic [19:0]      w_pfn1,
   input  logic [2:0]       w_c1,
   input  logic             w_d1,
   input  logic             w_v1,
   input  logic             r_req,
   input  logic [IDX_W-1:0] r_index,
   output logic             r_done,
   output logic [18:0]      r_vpn2,
   output logic [7:0]       r_asid,
   output logic             r_g,
   output logic [19:0]      r_pfn0,
   output logic [2:0]       r_c0,
   output logic             r_d0,
   output logic             r_v0,
   output logic [19:0]      r_pfn1,
   output logic [2:0]       r_c1,
   output logic             r_d1,
   output logic             r_v1
);
   logic        e_vld  [TLBNUM];
   logic [18:0] e_vpn2 [TLBNUM];
   logic [7:0]  e_asid [TLBNUM];
   logic        e_g    [TLBNUM];
   logic [19:0] e_pfn0 [TLBNUM];
   logic [2:0]  e_c0   [TLBNUM];
   logic        e_d0   [TLBNUM];
   logic        e_v0   [TLBNUM];
   logic [19:0] e_pfn1 [TLBNUM];
   logic [2:0]  e_c1   [TLBNUM];
   logic        e_d1   [TLBNUM];
   logic        e_v1   [TLBNUM];

   // Returns {hit, index}; scanning downward lets the lowest matching index win.
   function automatic logic [IDX_W:0] match(input logic [18:0] vpn2, input logic [7:0] asid);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (e_vld[i] && vpn2 == e_vpn2[i] && (e_g[i] || asid == e_asid[i]))
            res = {1'b1, IDX_W'(i)};
      end
      return res;
   endfunction

   // Returns {pfn, c, d, v} of the selected page, zero on a miss.
   function automatic logic [24:0] page(input logic [IDX_W:0] hit, input logic odd);
      logic [IDX_W-1:0] idx;
      idx = hit[IDX_W-1:0];
      if (!hit[IDX_W])
         return '0;
      else if (odd)
         return {e_pfn1[idx], e_c1[idx], e_d1[idx], e_v1[idx]};
      else
         return {e_pfn0[idx], e_c0[idx], e_d0[idx], e_v0[idx]};
   endfunction

   logic [IDX_W:0] s0_hit, s1_hit, p_hit;
   logic [24:0]    s0_page, s1_page;

   always_comb begin
      s0_hit  = match(s0_vpn2, s0_asid);
      s1_hit  = match(s1_vpn2, s1_asid);
      p_hit   = match(p_vpn2, p_asid);
      s0_page = page(s0_hit, s0_odd_page);
      s1_page = page(s1_hit, s1_odd_page);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) begin
            e_vld[i]  <= 1'b0;
            e_vpn2[i] <= '0;
            e_asid[i] <= '0;
            e_g[i]    <= 1'b0;
            e_pfn0[i] <= '0;
            e_c0[i]   <= '0;
            e_d0[i]   <= 1'b0;
            e_v0[i]   <= 1'b0;
            e_pfn1[i] <= '0;
            e_c1[i]   <= '0;
            e_d1[i]   <= 1'b0;
            e_v1[i]   <= 1'b0;
         end
      end else if (we) begin
         e_vld[w_index]  <= 1'b1;
         e_vpn2[w_index] <= w_vpn2;
         e_asid[w_index] <= w_asid;
         e_g[w_index]    <= w_g;
         e_pfn0[w_index] <= w_pfn0;
         e_c0[w_index]   <= w_c0;
         e_d0[w_index]   <= w_d0;
         e_v0[w_index]   <= w_v0;
         e_pfn1[w_index] <= w_pfn1;
         e_c1[w_index]   <= w_c1;
         e_d1[w_index]   <= w_d1;
         e_v1[w_index]   <= w_v1;
      end
   end

   // Result registers hold their value until the next request on the same port.
   always_ff @(posedge clk) begin
      if (reset) begin
         s0_rsp_vld <= 1'b0;
         s0_found   <= 1'b0;
         s0_index   <= '0;
         {s0_pfn, s0_c, s0_d, s0_v} <= '0;
         s1_rsp_vld <= 1'b0;
         s1_found   <= 1'b0;
         s1_index   <= '0;
         {s1_pfn, s1_c, s1_d, s1_v} <= '0;
         p_done     <= 1'b0;
         p_found    <= 1'b0;
         p_index    <= '0;
         r_done     <= 1'b0;
         {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} <= '0;
      end else begin
         s0_rsp_vld <= s0_req;
         s1_rsp_vld <= s1_req;
         p_done     <= p_req;
         r_done     <= r_req;
         if (s0_req) begin
            s0_found <= s0_hit[IDX_W];
            s0_index <= s0_hit[IDX_W-1:0];
            {s0_pfn, s0_c, s0_d, s0_v} <= s0_page;
         end
         if (s1_req) begin
            s1_found <= s1_hit[IDX_W];
            s1_index <= s1_hit[IDX_W-1:0];
            {s1_pfn, s1_c, s1_d, s1_v} <= s1_page;
         end
         if (p_req) begin
            p_found <= p_hit[IDX_W];
            p_index <= p_hit[IDX_W-1:0];
         end
         if (r_req) begin
            r_vpn2 <= e_vpn2[r_index];
            r_asid <= e_asid[r_index];
            r_g    <= e_g[r_index];
            r_pfn0 <= e_pfn0[r_index];
            r_c0   <= e_c0[r_index];
            r_d0   <= e_d0[r_index];
            r_v0   <= e_v0[r_index];
            r_pfn1 <= e_pfn1[r_index];
            r_c1   <= e_c1[r_index];
            r_d1   <= e_d1[r_index];
            r_v1   <= e_v1[r_index];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tlb_unit.sv
`default_nettype none
// tb_tlb_unit: directed and randomized checks of tlb_unit against an entry-table model.
// Revision 1.0
module tb_tlb_unit;
   localparam int TLBNUM = 16;
   localparam int IDX_W  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic s0_req, s0_odd_page, s0_rsp_vld, s0_found, s0_d, s0_v;
   logic [18:0] s0_vpn2;
   logic [7:0] s0_asid;
   logic [3:0] s0_index;
   logic [19:0] s0_pfn;
   logic [2:0] s0_c;
   logic s1_req, s1_odd_page, s1_rsp_vld, s1_found, s1_d, s1_v;
   logic [18:0] s1_vpn2;
   logic [7:0] s1_asid;
   logic [3:0] s1_index;
   logic [19:0] s1_pfn;
   logic [2:0] s1_c;
   logic p_req, p_done, p_found;
   logic [18:0] p_vpn2;
   logic [7:0] p_asid;
   logic [3:0] p_index;
   logic we, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [3:0] w_index;
   logic [18:0] w_vpn2;
   logic [7:0] w_asid;
   logic [19:0] w_pfn0, w_pfn1;
   logic [2:0] w_c0, w_c1;
   logic r_req, r_done, r_g, r_d0, r_v0, r_d1, r_v1;
   logic [3:0] r_index;
   logic [18:0] r_vpn2;
   logic [7:0] r_asid;
   logic [19:0] r_pfn0, r_pfn1;
   logic [2:0] r_c0, r_c1;

   tlb_unit #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset),
      .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
      .s0_rsp_vld(s0_rsp_vld), .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
      .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
      .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
      .s1_rsp_vld(s1_rsp_vld), .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
      .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
      .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid), .p_done(p_done), .p_found(p_found),
      .p_index(p_index),
      .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
      .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
      .r_req(r_req), .r_index(r_index), .r_done(r_done), .r_vpn2(r_vpn2), .r_asid(r_asid),
      .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
      .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
   );

   typedef struct packed {
      logic        vld;
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } ent_t;

   ent_t        m [TLBNUM];
   logic [30:0] exp_s0, exp_s1;
   logic [5:0]  exp_p;
   logic [78:0] exp_r;
   int          tests = 0;
   int          fails = 0;
   bit          checking = 1'b0;

   // {valid, found, index, pfn, c, d, v}; the first matching entry in index order wins.
   function automatic logic [30:0] mlook(input logic [18:0] vpn2, input logic [7:0] asid,
                                         input logic odd);
      for (int i = 0; i < TLBNUM; i++) begin
         if (m[i].vld && m[i].vpn2 == vpn2 && (m[i].g || m[i].asid == asid)) begin
            if (odd)
               return {2'b11, 4'(i), m[i].pfn1, m[i].c1, m[i].d1, m[i].v1};
            else
               return {2'b11, 4'(i), m[i].pfn0, m[i].c0, m[i].d0, m[i].v0};
         end
      end
      return {1'b1, 30'b0};
   endfunction

   always @(posedge clk) begin
      logic [30:0] lk;
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) m[i] <= '0;
         exp_s0 <= '0;
         exp_s1 <= '0;
         exp_p  <= '0;
         exp_r  <= '0;
      end else begin
         if (s0_req) exp_s0 <= mlook(s0_vpn2, s0_asid, s0_odd_page);
         else        exp_s0[30] <= 1'b0;
         if (s1_req) exp_s1 <= mlook(s1_vpn2, s1_asid, s1_odd_page);
         else        exp_s1[30] <= 1'b0;
         lk = mlook(p_vpn2, p_asid, 1'b0);
         if (p_req)  exp_p <= {1'b1, lk[29], lk[28:25]};
         else        exp_p[5] <= 1'b0;
         if (r_req)  exp_r <= {1'b1, m[r_index][77:0]};
         else        exp_r[78] <= 1'b0;
         if (we)
            m[w_index] <= {1'b1, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                           w_pfn1, w_c1, w_d1, w_v1};
      end
   end

   task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("s0", 80'({s0_rsp_vld, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}), 80'(exp_s0));
         chk("s1", 80'({s1_rsp_vld, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}), 80'(exp_s1));
         chk("probe", 80'({p_done, p_found, p_index}), 80'(exp_p));
         chk("read", 80'({r_done, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                          r_pfn1, r_c1, r_d1, r_v1}), 80'(exp_r));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      s0_req = 0; s1_req = 0; p_req = 0; r_req = 0; we = 0;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                     input logic g, input logic [19:0] pfn0, input logic [19:0] pfn1);
      we = 1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
      w_pfn0 = pfn0; w_c0 = 3'd2; w_d0 = 0; w_v0 = 1;
      w_pfn1 = pfn1; w_c1 = 3'd3; w_d1 = 1; w_v1 = 1;
   endtask

   task automatic look0(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
      s0_req = 1; s0_vpn2 = vpn2; s0_asid = asid; s0_odd_page = odd;
   endtask

   task automatic look1(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
      s1_req = 1; s1_vpn2 = vpn2; s1_asid = asid; s1_odd_page = odd;
   endtask

   initial begin
      reset = 1;
      idle();
      s0_vpn2 = 0; s0_asid = 0; s0_odd_page = 0;
      s1_vpn2 = 0; s1_asid = 0; s1_odd_page = 0;
      p_vpn2 = 0; p_asid = 0; r_index = 0;
      wr(0, 0, 0, 0, 0, 0);
      we = 0;
      cyc();
      checking = 1;
      cyc();
      reset = 0;

      look0(19'h0, 8'h0, 0); r_req = 1; r_index = 4'd3;
      cyc(); idle();
      chk("lit_s0_after_reset", 80'({s0_rsp_vld, s0_found}), 80'(2'b10));
      chk("lit_read_unwritten", 80'({r_done, r_vpn2, r_asid, r_g, r_pfn0, r_pfn1}), 80'(1) << 68);

      wr(5, 19'h00400, 8'h12, 0, 20'h1A, 20'h1B);
      cyc(); idle();
      look1(19'h00400, 8'h12, 1);
      cyc(); idle();
      chk("lit_s1_hit", 80'({s1_found, s1_index, s1_pfn, s1_d}), 80'({1'b1, 4'd5, 20'h1B, 1'b1}));
      look1(19'h00400, 8'h13, 1);
      cyc(); idle();
      chk("lit_s1_asid_miss", 80'({s1_rsp_vld, s1_found, s1_index, s1_pfn}), 80'(1) << 25);

      wr(5, 19'h00400, 8'h12, 1, 20'h1A, 20'h1B);
      cyc(); idle();
      look0(19'h00400, 8'h77, 0); p_req = 1; p_vpn2 = 19'h00400; p_asid = 8'h00;
      cyc(); idle();
      chk("lit_global_hit", 80'({s0_found, s0_pfn}), 80'({1'b1, 20'h1A}));
      chk("lit_probe", 80'({p_done, p_found, p_index}), 80'({2'b11, 4'd5}));

      wr(2, 19'h12345, 8'h03, 0, 20'h2222, 20'h2223);
      cyc();
      wr(9, 19'h12345, 8'h03, 0, 20'h9999, 20'h999A);
      cyc(); idle();
      look0(19'h12345, 8'h03, 0);
      cyc(); idle();
      chk("lit_lowest_index", 80'({s0_found, s0_index}), 80'({1'b1, 4'd2}));
      wr(2, 19'h00001, 8'h03, 0, 20'h2222, 20'h2223);
      cyc(); idle();
      look0(19'h12345, 8'h03, 0);
      cyc(); idle();
      chk("lit_after_invalidate", 80'({s0_found, s0_index, s0_pfn}), 80'({1'b1, 4'd9, 20'h9999}));

      wr(7, 19'h07000, 8'h05, 0, 20'h7070, 20'h7071);
      cyc(); idle();
      wr(7, 19'h07777, 8'h05, 0, 20'h7777, 20'h7778);
      look0(19'h07000, 8'h05, 1);
      cyc(); idle();
      chk("lit_same_cycle_old", 80'({s0_found, s0_index, s0_pfn}), 80'({1'b1, 4'd7, 20'h7071}));
      look0(19'h07000, 8'h05, 1);
      cyc(); idle();
      chk("lit_old_vpn_gone", 80'({s0_rsp_vld, s0_found}), 80'(2'b10));

      reset = 1; look0(19'h00400, 8'h12, 0); p_req = 1; r_req = 1;
      cyc(); idle(); reset = 0;
      chk("lit_reset_drops", 80'({s0_rsp_vld, p_done, r_done}), 80'(3'b000));
      look0(19'h12345, 8'h03, 0); look1(19'h00400, 8'h12, 1);
      cyc(); idle();
      chk("lit_cleared_s0", 80'({s0_rsp_vld, s0_found}), 80'(2'b10));
      chk("lit_cleared_s1", 80'({s1_rsp_vld, s1_found}), 80'(2'b10));

      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         s0_req = $urandom_range(0, 1) == 1;
         s1_req = $urandom_range(0, 1) == 1;
         p_req  = $urandom_range(0, 2) == 0;
         r_req  = $urandom_range(0, 2) == 0;
         we     = $urandom_range(0, 2) == 0;
         s0_vpn2 = 19'h00400 + 19'($urandom_range(0, 3));
         s1_vpn2 = 19'h00400 + 19'($urandom_range(0, 3));
         p_vpn2  = 19'h00400 + 19'($urandom_range(0, 3));
         w_vpn2  = 19'h00400 + 19'($urandom_range(0, 3));
         s0_asid = 8'($urandom_range(0, 3));
         s1_asid = 8'($urandom_range(0, 3));
         p_asid  = 8'($urandom_range(0, 3));
         w_asid  = 8'($urandom_range(0, 3));
         s0_odd_page = $urandom_range(0, 1) == 1;
         s1_odd_page = $urandom_range(0, 1) == 1;
         w_index = 4'($urandom_range(0, 15));
         r_index = 4'($urandom_range(0, 15));
         w_g  = $urandom_range(0, 3) == 0;
         w_pfn0 = 20'($urandom); w_pfn1 = 20'($urandom);
         w_c0 = 3'($urandom); w_c1 = 3'($urandom);
         w_d0 = 1'($urandom); w_v0 = 1'($urandom);
         w_d1 = 1'($urandom); w_v1 = 1'($urandom);
         cyc();
      end
      reset = 0;
      idle();
      cyc();
      checking = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
